// File: rtl/vga_write_arbiter.sv
`default_nettype none
// ============================================================================
// vga_write_arbiter : round-robin arbiter of three text-cell writers onto one
//                     registered VGA memory write port, with full-screen clear
// Revision 1.0
// ============================================================================
module vga_write_arbiter #(
  parameter int unsigned SCREEN_CELLS = 2400,
  parameter logic [15:0] CLEAR_DATA   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [35:0] req_addr,
  input  logic [47:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        addr_err,
  output logic [11:0] vga_addr,
  output logic        vga_we,
  output logic [15:0] vga_data
);

  localparam logic [0:0]  ST_RUN     = 1'b0;
  localparam logic [0:0]  ST_CLEAR   = 1'b1;
  localparam logic [11:0] LAST_CELL  = 12'(SCREEN_CELLS - 1);
  localparam logic [12:0] CELL_LIMIT = 13'(SCREEN_CELLS);

  logic [0:0]  state_q, state_d;
  logic [11:0] k_q, k_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic        vga_we_q, vga_we_d;
  logic [11:0] vga_addr_q, vga_addr_d;
  logic [15:0] vga_data_q, vga_data_d;
  logic        clear_busy_q, clear_busy_d;
  logic        clear_done_q, clear_done_d;
  logic        addr_err_q, addr_err_d;

  logic        win_valid;
  logic [1:0]  win_idx;
  logic [11:0] win_addr;
  logic [15:0] win_data;
  logic        grant_en;

  // Requester index at offset `off` past the last grant, modulo 3.
  function automatic logic [1:0] rr_idx(input logic [1:0] lg, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, lg} + {1'b0, off} + 3'd1;
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int j = 0; j < 3; j++) begin
      if (!win_valid && req_valid[rr_idx(last_grant_q, 2'(j))]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx(last_grant_q, 2'(j));
      end
    end
  end

  always_comb begin
    win_addr = req_addr[11:0];
    win_data = req_data[15:0];
    case (win_idx)
      2'd1: begin
        win_addr = req_addr[23:12];
        win_data = req_data[31:16];
      end
      2'd2: begin
        win_addr = req_addr[35:24];
        win_data = req_data[47:32];
      end
      default: ;
    endcase
  end

  // A clear request pre-empts arbitration in the cycle it is seen.
  assign grant_en  = (state_q == ST_RUN) && !clear_start && !rst && win_valid;
  assign req_ready = grant_en ? (3'b001 << win_idx) : 3'b000;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    last_grant_d = last_grant_q;
    vga_we_d     = 1'b0;
    vga_addr_d   = vga_addr_q;
    vga_data_d   = vga_data_q;
    clear_busy_d = 1'b0;
    clear_done_d = 1'b0;
    addr_err_d   = addr_err_q;

    if (state_q == ST_RUN) begin
      if (clear_start) begin
        state_d = ST_CLEAR;
        k_d     = 12'd0;
      end else if (grant_en) begin
        last_grant_d = win_idx;
        if ({1'b0, win_addr} < CELL_LIMIT) begin
          vga_we_d   = 1'b1;
          vga_addr_d = win_addr;
          vga_data_d = win_data;
        end else begin
          addr_err_d = 1'b1;
        end
      end
    end else begin
      vga_we_d     = 1'b1;
      vga_addr_d   = k_q;
      vga_data_d   = CLEAR_DATA;
      clear_busy_d = 1'b1;
      if (k_q == LAST_CELL) begin
        state_d      = ST_RUN;
        k_d          = 12'd0;
        clear_done_d = 1'b1;
      end else begin
        k_d = k_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      k_q          <= 12'd0;
      last_grant_q <= 2'd2;
      vga_we_q     <= 1'b0;
      vga_addr_q   <= 12'd0;
      vga_data_q   <= 16'd0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      last_grant_q <= last_grant_d;
      vga_we_q     <= vga_we_d;
      vga_addr_q   <= vga_addr_d;
      vga_data_q   <= vga_data_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign vga_we     = vga_we_q;
  assign vga_addr   = vga_addr_q;
  assign vga_data   = vga_data_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
  assign addr_err   = addr_err_q;

endmodule
`default_nettype wire

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 SHALL have parameter SCREEN_CELLS, default 2400: number of text cells (80x30); valid addresses are 0..SCREEN_CELLS-1.
REQ-002 SHALL have parameter CLEAR_DATA, default 16'h0000: cell word written during screen clear.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 3: per-requester write request (bit i = requester i).
REQ-006 SHALL have port req_addr, input, 36: requester i cell address in bits [12i+11:12i].
REQ-007 SHALL have port req_data, input, 48: requester i cell word in bits [16i+15:16i].
REQ-008 SHALL have port req_ready, output, 3: combinational grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-009 SHALL have port clear_start, input, 1: pulse requesting a full-screen clear.
REQ-010 SHALL have port clear_busy, output, 1: high while in CLEAR.
REQ-011 SHALL have port clear_done, output, 1: one-cycle pulse marking the final clear write.
REQ-012 SHALL have port addr_err, output, 1: sticky flag set on an out-of-range request.
REQ-013 SHALL have ports vga_addr (output, 12), vga_we (output, 1) and vga_data (output, 16): the registered, shared VGA text-memory write port.

Function
REQ-014 SHALL implement two states: RUN and CLEAR.
REQ-015 In RUN, SHALL grant at most one requester per cycle, chosen round-robin from the valid requesters, searching from (last_grant+1) mod 3 upward.
REQ-016 SHALL assert req_ready only for the winner; all other bits are 0, and all bits are 0 when no requester is valid.
REQ-017 On a transfer, SHALL update last_grant to the winner's index.
REQ-018 On a transfer, SHALL drive vga_we=1 with the winner's vga_addr/vga_data in the next cycle (latency 1).
REQ-019 SHALL drive vga_we=0 in any cycle following a cycle with no transfer; vga_addr/vga_data then hold their previous values.
REQ-020 On a transfer with address >= SCREEN_CELLS, SHALL still consume the request but drive vga_we=0 next cycle and set addr_err=1; addr_err clears only on reset.
REQ-021 In RUN, clear_start=1 SHALL move the state to CLEAR next cycle and force req_ready=0 in that same cycle; clear takes priority over simultaneous requests.
REQ-022 In CLEAR, SHALL force req_ready=3'b000 and step a cell counter k from 0 to SCREEN_CELLS-1, one cell per cycle.
REQ-023 For each k, SHALL drive vga_we=1, vga_addr=k, vga_data=CLEAR_DATA in the following cycle.
REQ-024 On k=SCREEN_CELLS-1, SHALL return to RUN, reset k to 0, and pulse clear_done in the cycle that vga_addr=SCREEN_CELLS-1 is presented.
REQ-025 SHALL ignore clear_start while in CLEAR; there is no restart and no queuing.
REQ-026 SHALL register clear_busy, high exactly during the SCREEN_CELLS cycles in which clear writes are presented.
REQ-027 SHALL permit arbitration in the first RUN cycle after CLEAR, so a request then is presented in the same cycle as clear_done+1.
REQ-028 SHALL use 12-bit address arithmetic with no wrap within 0..SCREEN_CELLS-1; SCREEN_CELLS <= 4096.

Reset
REQ-029 On rst=1, SHALL, at the next edge: state=RUN, k=0, last_grant=2, vga_we=0, vga_addr=0, vga_data=0, clear_busy=0, clear_done=0, addr_err=0.
REQ-030 SHALL hold req_ready=0 while rst=1.
REQ-031 Reset asserted mid-clear SHALL abort the clear with no clear_done pulse.

Verification
REQ-032 SHALL pass: single write, req_valid=3'b010, addr=812, data=16'h0e01 -> req_ready=3'b010 same cycle; next cycle vga_we=1, vga_addr=812, vga_data=16'h0e01.
REQ-033 SHALL pass: fairness, all three valid continuously from reset -> grants 0,1,2,0,1,2; each requester gets exactly 1 of every 3 writes.
REQ-034 SHALL pass: clear, clear_start pulse with req_valid=3'b111 -> req_ready=0 for 2401 cycles; 2400 writes to addr 0..2399 with data 16'h0000; clear_done coincident with addr 2399; requester 0 granted the next cycle.
REQ-035 SHALL pass: out-of-range, addr=2400 on requester 2 -> req_ready[2]=1; next cycle vga_we=0 and addr_err=1, held until reset.
REQ-036 SHALL pass: reset mid-clear, rst at k=1000 -> next cycle vga_we=0, clear_busy=0, no clear_done; a subsequent clear restarts at addr 0.
REQ-037 SHALL pass: clear_start re-pulsed during CLEAR -> no effect; total clear length remains exactly 2400 writes.
